// File: rtl/shift_phase_interp.sv
// Fractional-delay interpolator: y = x[n-1] + mu*(x[n]-x[n-1]) per lane, AXI-Stream in/out.
// Define SHIFT_PHASE_INTERP_TLAST_EN to add tlast framing (history re-primes after each frame end).
module shift_phase_interp #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2,
    parameter int FRAC_W   = 8
) (
    input  logic                         s_axis_aclk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [FRAC_W-1:0]            mu_i,
    input  logic [CHANNELS*DATA_W-1:0]   s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
`ifdef SHIFT_PHASE_INTERP_TLAST_EN
    input  logic                         s_axis_tlast,
    output logic                         m_axis_tlast,
`endif
    output logic [CHANNELS*DATA_W-1:0]   m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready
);

    localparam int DIFF_W = DATA_W + 1;
    localparam int PROD_W = DATA_W + FRAC_W + 2;
    localparam logic signed [PROD_W-1:0] ROUND = PROD_W'(1) << (FRAC_W - 1);
    localparam logic signed [PROD_W-1:0] Y_MAX = (PROD_W'(1) << (DATA_W - 1)) - PROD_W'(1);
    localparam logic signed [PROD_W-1:0] Y_MIN = -(PROD_W'(1) << (DATA_W - 1));

    logic ce;
    logic accept;
    logic primed;
    logic v1;
    logic [FRAC_W-1:0] mu_q;
    logic [CHANNELS*DATA_W-1:0] y_packed;

    logic signed [DATA_W-1:0] hist_q [CHANNELS];
    logic signed [DATA_W-1:0] base_q [CHANNELS];
    logic signed [DIFF_W-1:0] diff_q [CHANNELS];
    logic signed [DIFF_W-1:0] diff_d [CHANNELS];

`ifdef SHIFT_PHASE_INTERP_TLAST_EN
    logic last1_q;
`endif

    assign ce            = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = ce && !flush;
    assign accept        = s_axis_tvalid && s_axis_tready;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic signed [DATA_W-1:0] x;
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] rounded;
        logic signed [PROD_W-1:0] sum;
        logic signed [DATA_W-1:0] y_d;

        assign x         = s_axis_tdata[k*DATA_W +: DATA_W];
        assign diff_d[k] = $signed({x[DATA_W-1], x}) - $signed({hist_q[k][DATA_W-1], hist_q[k]});

        // mu is zero-extended so the product stays signed; the +half then arithmetic shift rounds toward +inf
        assign prod    = $signed({{(PROD_W-DIFF_W){diff_q[k][DIFF_W-1]}}, diff_q[k]})
                       * $signed({{(PROD_W-FRAC_W){1'b0}}, mu_q});
        assign rounded = (prod + ROUND) >>> FRAC_W;
        assign sum     = $signed({{(PROD_W-DATA_W){base_q[k][DATA_W-1]}}, base_q[k]}) + rounded;

        always_comb begin
            y_d = sum[DATA_W-1:0];
            if (sum > Y_MAX)
                y_d = Y_MAX[DATA_W-1:0];
            else if (sum < Y_MIN)
                y_d = Y_MIN[DATA_W-1:0];
        end

        assign y_packed[k*DATA_W +: DATA_W] = y_d;
    end

    // flush outranks ce so a stalled pipeline can still be emptied
    always_ff @(posedge s_axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            primed        <= 1'b0;
            v1            <= 1'b0;
            mu_q          <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                hist_q[k] <= '0;
                base_q[k] <= '0;
                diff_q[k] <= '0;
            end
`ifdef SHIFT_PHASE_INTERP_TLAST_EN
            last1_q       <= 1'b0;
            m_axis_tlast  <= 1'b0;
`endif
        end else if (flush) begin
            primed        <= 1'b0;
            v1            <= 1'b0;
            m_axis_tvalid <= 1'b0;
            for (int k = 0; k < CHANNELS; k++)
                hist_q[k] <= '0;
`ifdef SHIFT_PHASE_INTERP_TLAST_EN
            last1_q       <= 1'b0;
            m_axis_tlast  <= 1'b0;
`endif
        end else if (ce) begin
            v1            <= accept && primed;
            m_axis_tvalid <= v1;
            m_axis_tdata  <= y_packed;
`ifdef SHIFT_PHASE_INTERP_TLAST_EN
            m_axis_tlast  <= v1 && last1_q;
`endif
            if (accept) begin
                mu_q <= mu_i;
                for (int k = 0; k < CHANNELS; k++) begin
                    hist_q[k] <= s_axis_tdata[k*DATA_W +: DATA_W];
                    base_q[k] <= hist_q[k];
                    diff_q[k] <= diff_d[k];
                end
`ifdef SHIFT_PHASE_INTERP_TLAST_EN
                last1_q <= s_axis_tlast;
                primed  <= !s_axis_tlast;
`else
                primed  <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_shift_phase_interp.sv
// Directed self-checking bench for shift_phase_interp (two 16-bit lanes, FRAC_W=8).
`timescale 1ns/1ps
module tb_shift_phase_interp;

    logic        s_axis_aclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  mu_i = 8'd0;
    logic [31:0] s_axis_tdata = 32'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
`ifdef SHIFT_PHASE_INTERP_TLAST_EN
    logic        s_axis_tlast = 1'b0;
    logic        m_axis_tlast;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_accept_cyc = 0;
    logic last_sent = 1'b0;

    logic [31:0] out_q[$];
    int          out_cyc[$];
    logic        out_last[$];

    shift_phase_interp #(.DATA_W(16), .CHANNELS(2), .FRAC_W(8)) dut (
        .s_axis_aclk  (s_axis_aclk),
        .rst_n        (rst_n),
        .flush        (flush),
        .mu_i         (mu_i),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
`ifdef SHIFT_PHASE_INTERP_TLAST_EN
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tlast (m_axis_tlast),
`endif
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

    always #5 s_axis_aclk = ~s_axis_aclk;

    always @(posedge s_axis_aclk) cyc++;

    // A handshake seen at the falling edge completes at the following rising edge
    always @(negedge s_axis_aclk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            out_q.push_back(m_axis_tdata);
            out_cyc.push_back(cyc);
`ifdef SHIFT_PHASE_INTERP_TLAST_EN
            out_last.push_back(m_axis_tlast);
`else
            out_last.push_back(1'b0);
`endif
        end
    end

    function automatic logic [31:0] pack(input int lane0, input int lane1);
        return {16'(lane1), 16'(lane0)};
    endfunction

    task automatic clear_outputs();
        out_q.delete();
        out_cyc.delete();
        out_last.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge s_axis_aclk);
            #1;
        end
    endtask

    task automatic send_beat(input int lane0, input int lane1, input logic [7:0] mu, input logic last);
        int   waited;
        logic rdy;
        waited = 0;
        rdy = 1'b0;
        s_axis_tdata  = pack(lane0, lane1);
        mu_i          = mu;
        last_sent     = last;
`ifdef SHIFT_PHASE_INTERP_TLAST_EN
        s_axis_tlast  = last;
`endif
        s_axis_tvalid = 1'b1;
        while (!rdy && waited < 50) begin
            @(negedge s_axis_aclk);
            rdy = s_axis_tready;
            if (rdy) last_accept_cyc = cyc;
            @(posedge s_axis_aclk);
            #1;
            waited++;
        end
        s_axis_tvalid = 1'b0;
        if (!rdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_beat_timeout got=no_accept exp=accept lane0=%0d", lane0);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge s_axis_aclk);
        #1;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        @(negedge s_axis_aclk);
        checks += 3;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
        if (m_axis_tdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
        if (s_axis_tready !== 1'b1) begin errors++; $display("[TB] FAIL reset_tready got=%b exp=1", s_axis_tready); end
        @(posedge s_axis_aclk);
        #1;
    endtask

    task automatic test_half_shift();
        int acc2;
        int exp0[3] = '{50, 150, 250};
        logic [31:0] got;
        clear_outputs();
        send_beat(0, 0, 8'd128, 1'b0);
        send_beat(100, 0, 8'd128, 1'b0);
        acc2 = last_accept_cyc;
        send_beat(200, 0, 8'd128, 1'b0);
        send_beat(300, 0, 8'd128, 1'b0);
        idle(5);
        checks += 2;
        if (out_q.size() != 3) begin errors++; $display("[TB] FAIL half_count got=%0d exp=3", out_q.size()); end
        if (out_cyc.size() == 0 || out_cyc[0] - acc2 != 2) begin
            errors++;
            $display("[TB] FAIL half_latency got=%0d exp=2", (out_cyc.size() == 0) ? -1 : out_cyc[0] - acc2);
        end
        for (int i = 0; i < 3; i++) begin
            got = (out_q.size() > i) ? out_q[i] : 32'hxxxxxxxx;
            checks++;
            if (got !== pack(exp0[i], 0)) begin
                errors++;
                $display("[TB] FAIL half_out%0d got=%h exp=%h", i, got, pack(exp0[i], 0));
            end
        end
    endtask

    task automatic test_rounding();
        int a0[4]  = '{-3, 0, 7, -32768};
        int b0[4]  = '{-4, 256, -9, 32767};
        int a1[4]  = '{10, -100, 5, 32767};
        int b1[4]  = '{20, 100, -5, -32768};
        int mu[4]  = '{128, 255, 0, 255};
        int e0[4]  = '{-3, 255, 7, 32511};
        int e1[4]  = '{15, 99, 5, -32512};
        logic [31:0] got;
        for (int i = 0; i < 4; i++) begin
            do_flush();
            clear_outputs();
            send_beat(a0[i], a1[i], 8'(mu[i]), 1'b0);
            send_beat(b0[i], b1[i], 8'(mu[i]), 1'b0);
            idle(4);
            got = (out_q.size() > 0) ? out_q[0] : 32'hxxxxxxxx;
            checks += 3;
            if (out_q.size() != 1) begin errors++; $display("[TB] FAIL round%0d_count got=%0d exp=1", i, out_q.size()); end
            if (got[15:0] !== 16'(e0[i])) begin
                errors++;
                $display("[TB] FAIL round%0d_lane0 got=%0d exp=%0d", i, $signed(got[15:0]), e0[i]);
            end
            if (got[31:16] !== 16'(e1[i])) begin
                errors++;
                $display("[TB] FAIL round%0d_lane1 got=%0d exp=%0d", i, $signed(got[31:16]), e1[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] expd;
        logic [31:0] got;
        int n;
        do_flush();
        clear_outputs();
        fork
            begin
                for (int i = 0; i < 10; i++) send_beat(i * 10, -i * 10, 8'd64, 1'b0);
            end
            begin
                repeat (5) @(posedge s_axis_aclk);
                #1;
                m_axis_tready = 1'b0;
                n = out_q.size();
                expd = pack(n * 10 + 3, -(n * 10) - 2);
                for (int j = 0; j < 5; j++) begin
                    @(negedge s_axis_aclk);
                    checks += 2;
                    if (s_axis_tready !== 1'b0) begin errors++; $display("[TB] FAIL stall_tready%0d got=%b exp=0", j, s_axis_tready); end
                    if (m_axis_tdata !== expd) begin errors++; $display("[TB] FAIL stall_tdata%0d got=%h exp=%h", j, m_axis_tdata, expd); end
                    @(posedge s_axis_aclk);
                    #1;
                end
                m_axis_tready = 1'b1;
            end
        join
        idle(5);
        checks++;
        if (out_q.size() != 9) begin errors++; $display("[TB] FAIL bp_count got=%0d exp=9", out_q.size()); end
        for (int k = 0; k < 9; k++) begin
            got = (out_q.size() > k) ? out_q[k] : 32'hxxxxxxxx;
            checks++;
            if (got !== pack(k * 10 + 3, -(k * 10) - 2)) begin
                errors++;
                $display("[TB] FAIL bp_out%0d got=%h exp=%h", k, got, pack(k * 10 + 3, -(k * 10) - 2));
            end
        end
    endtask

    task automatic test_flush_mid();
        int exp0[3] = '{5, 15, 150};
        logic [31:0] got;
        do_flush();
        clear_outputs();
        for (int i = 0; i < 4; i++) send_beat(i * 10, 0, 8'd128, 1'b0);
        flush = 1'b1;
        s_axis_tdata = pack(999, 999);
        s_axis_tvalid = 1'b1;
        @(negedge s_axis_aclk);
        checks++;
        if (s_axis_tready !== 1'b0) begin errors++; $display("[TB] FAIL flush_tready got=%b exp=0", s_axis_tready); end
        @(posedge s_axis_aclk);
        #1;
        flush = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge s_axis_aclk);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL flush_tvalid got=%b exp=0", m_axis_tvalid); end
        @(posedge s_axis_aclk);
        #1;
        send_beat(100, 0, 8'd128, 1'b0);
        send_beat(200, 0, 8'd128, 1'b0);
        idle(4);
        checks++;
        if (out_q.size() != 3) begin errors++; $display("[TB] FAIL flush_count got=%0d exp=3", out_q.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (out_q.size() > i) ? out_q[i] : 32'hxxxxxxxx;
            checks++;
            if (got !== pack(exp0[i], 0)) begin
                errors++;
                $display("[TB] FAIL flush_out%0d got=%h exp=%h", i, got, pack(exp0[i], 0));
            end
        end
    endtask

    task automatic test_reset_mid();
        int exp0[2] = '{5, 150};
        logic [31:0] got;
        do_flush();
        clear_outputs();
        for (int i = 0; i < 4; i++) send_beat(i * 10, 0, 8'd128, 1'b0);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge s_axis_aclk);
        checks += 2;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_tvalid got=%b exp=0", m_axis_tvalid); end
        if (m_axis_tdata !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_tdata got=%h exp=0", m_axis_tdata); end
        @(posedge s_axis_aclk);
        #1;
        send_beat(100, 0, 8'd128, 1'b0);
        send_beat(200, 0, 8'd128, 1'b0);
        idle(4);
        checks++;
        if (out_q.size() != 2) begin errors++; $display("[TB] FAIL rstmid_count got=%0d exp=2", out_q.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (out_q.size() > i) ? out_q[i] : 32'hxxxxxxxx;
            checks++;
            if (got !== pack(exp0[i], 0)) begin
                errors++;
                $display("[TB] FAIL rstmid_out%0d got=%h exp=%h", i, got, pack(exp0[i], 0));
            end
        end
    endtask

`ifdef SHIFT_PHASE_INTERP_TLAST_EN
    task automatic test_tlast();
        int   exp0[3] = '{15, 25, 150};
        logic expl[3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] got;
        logic gotl;
        do_flush();
        clear_outputs();
        send_beat(10, 0, 8'd128, 1'b0);
        send_beat(20, 0, 8'd128, 1'b0);
        send_beat(30, 0, 8'd128, 1'b1);
        send_beat(100, 0, 8'd128, 1'b0);
        send_beat(200, 0, 8'd128, 1'b0);
        idle(4);
        checks++;
        if (out_q.size() != 3) begin errors++; $display("[TB] FAIL tlast_count got=%0d exp=3", out_q.size()); end
        for (int i = 0; i < 3; i++) begin
            got  = (out_q.size() > i) ? out_q[i] : 32'hxxxxxxxx;
            gotl = (out_last.size() > i) ? out_last[i] : 1'bx;
            checks += 2;
            if (got !== pack(exp0[i], 0)) begin errors++; $display("[TB] FAIL tlast_out%0d got=%h exp=%h", i, got, pack(exp0[i], 0)); end
            if (gotl !== expl[i]) begin errors++; $display("[TB] FAIL tlast_flag%0d got=%b exp=%b", i, gotl, expl[i]); end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1;
        test_reset();
        test_half_shift();
        test_rounding();
        test_backpressure();
        test_flush_mid();
        test_reset_mid();
`ifdef SHIFT_PHASE_INTERP_TLAST_EN
        test_tlast();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_phase_interp.md
Name: shift_phase_interp

Overview:
- Parametrised fractional-delay interpolator for the modem sample path.
- Per channel: y[n] = x[n-1] + mu*(x[n]-x[n-1]), where mu is an unsigned fraction in [0,1).
- mu = 0.5 gives the two-sample average used for half-sample phase shift. Other mu values give arbitrary sub-sample phase.
- Sits between ADC/DDC sample stream and timing recovery. AXI-Stream in and out with full backpressure; CHANNELS lanes packed in one beat (I/Q).

Parameters:
- DATA_W, 16, signed sample width per channel
- CHANNELS, 2, lanes packed in tdata; lane k = tdata[k*DATA_W +: DATA_W]
- FRAC_W, 8, width of mu; mu value = mu_i / 2^FRAC_W

Ports:
- s_axis_aclk  in  1  single clock for both stream sides
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; clears history and pipeline
- mu_i  in  FRAC_W  fraction, sampled with each accepted input beat
- s_axis_tdata  in  CHANNELS*DATA_W  input samples
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  CHANNELS*DATA_W  interpolated samples
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready

Behaviour:
- Clock and reset: one clock, s_axis_aclk. rst_n is asynchronous and active-low.
- Reset values: m_axis_tdata=0, m_axis_tvalid=0, history=0, primed=0, all stage valids=0. s_axis_tready follows the formula below, so it reads 1 while out of reset.
- Pipeline enable: ce = !m_axis_tvalid || m_axis_tready. s_axis_tready = ce (combinational). Accept = s_axis_tvalid && s_axis_tready.
- Priming:
  - The first accept after reset or flush only loads history x[n-1] and sets primed. No output is produced for it.
  - Every later accept enters stage 1.
- Stage 1 (on ce):
  - diff_k = x[n]-x[n-1], signed, DATA_W+1 bits.
  - Register base_k = x[n-1], diff_k and mu.
  - history <= x[n].
  - v1 <= accept && primed.
- Stage 2 (on ce):
  - p_k = diff_k * {1'b0,mu}, signed.
  - y_k = base_k + ((p_k + 2^(FRAC_W-1)) >>> FRAC_W), using arithmetic shift, which rounds half toward +inf.
  - Clamp y_k to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. This is defensive only; the result mathematically lies between the two samples.
  - m_axis_tdata <= packed y. m_axis_tvalid <= v1.
- Latency: a sample accepted at cycle t (primed) appears with m_axis_tvalid at cycle t+2 when there is no stall.
- Throughput: one beat per cycle while m_axis_tready=1.
- Stall: while m_axis_tvalid && !m_axis_tready, all stages and history hold, and s_axis_tready=0. m_axis_tdata must stay stable. No beat is lost or duplicated.
- Gap: s_axis_tvalid=0 with ce=1 inserts a bubble (v1=0). History is unchanged.
- flush (when ce irrelevant): next edge clears primed, history, v1 and m_axis_tvalid. A beat presented in the same cycle as flush is not accepted (s_axis_tready forced 0 during flush).
- rst_n deasserted mid-stream: all state clears immediately. The first beat after release primes.
- Lanes are independent. mu is shared by all lanes of a beat.

Optional Feature:
- Macro SHIFT_PHASE_INTERP_TLAST_EN.
- When defined:
  - Adds ports s_axis_tlast (in, 1) and m_axis_tlast (out, 1).
  - tlast propagates with its beat through the pipeline. A primed beat carries tlast to the output.
  - An accepted beat with tlast=1 clears primed after loading history, so the next beat starts a new frame and re-primes. No interpolation across frame boundaries.
  - A priming beat carrying tlast produces no output, and its tlast is dropped.
- When undefined: no tlast ports, and the stream is continuous.

Test Plan:
- Reset: hold rst_n=0, then release -> m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=1.
- Half-sample shift, FRAC_W=8, mu=128, lane0 inputs 0,100,200,300 back-to-back -> outputs 50,150,250. First output 2 cycles after the second accept. Exactly 3 outputs.
- Rounding and sign, mu=128:
  - inputs -3,-4 -> output -3 (-3.5 rounds up).
  - mu=255, inputs 0,256 -> output 255.
  - mu=0, inputs 7,-9 -> output 7.
  - Lane1 driven with different data is checked independently.
- Backpressure: stream 10 beats of a ramp, with m_axis_tready=0 for 5 cycles mid-stream -> s_axis_tready=0 during the stall, m_axis_tdata stable, all 9 outputs in order with no loss.
- Flush and reset mid-stream:
  - Pulse flush after 4 beats -> in-flight output dropped; the next beat primes; the following beat produces output.
  - Repeat with rst_n pulsed asynchronously between edges -> same recovery.
- With SHIFT_PHASE_INTERP_TLAST_EN: frames [10,20,30 tlast] and [100,200] at mu=128:
  - Outputs 15, 25 (tlast=1 on 25), then 150.
  - No output mixes 30 with 100.
